// File: rtl/wm8731_avalon_slave_if.sv
// wm8731_avalon_slave_if: Avalon-MM slave port bundle for the WM8731 register block.
// The master modport is the bus side (CPU / interconnect); the slave modport is the
// register block side.

interface wm8731_avalon_slave_if;
  logic        slave_read;
  logic        slave_write;
  logic        slave_chipselect;
  logic        slave_beginbursttransfer;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata;
  logic [7:0]  slave_burstcount;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic        slave_irq;

  modport master (
    output slave_read,
    output slave_write,
    output slave_chipselect,
    output slave_beginbursttransfer,
    output slave_address,
    output slave_writedata,
    output slave_burstcount,
    input  slave_readdata,
    input  slave_waitrequest,
    input  slave_irq
  );

  modport slave (
    input  slave_read,
    input  slave_write,
    input  slave_chipselect,
    input  slave_beginbursttransfer,
    input  slave_address,
    input  slave_writedata,
    input  slave_burstcount,
    output slave_readdata,
    output slave_waitrequest,
    output slave_irq
  );
endinterface

// File: rtl/wm8731_avalon_slave.sv
// wm8731_avalon_slave: Avalon-MM register slave for a WM8731 codec front end.
// Registers: 0 I2C_DATA_AUDIO, 1 DAC_AUDIO (DAC FIFO push), 2 ADC_AUDIO (ADC FIFO pop),
// 3 STATUS, 4 IRQ_EN. Single clock, synchronous active-high Reset.
// Define WM8731_ADC_PATH_EN to build the ADC capture path (ADC FIFO, ADC_AUDIO,
// burst reads, adc_overflow, IRQ_EN[0]); without it the ADC inputs are ignored.
// Reads: the read data is captured when the request is taken in IDLE, so it is
// already valid in RD_WAIT, the cycle in which waitrequest drops and the transfer
// completes. Writes complete in the first cycle when the target is ready.

module wm8731_avalon_slave #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  wm8731_avalon_slave_if.slave avs,
  output logic                 i2c_start,
  output logic [23:0]          i2c_packet,
  input  logic                 i2c_busy,
  input  logic                 i2c_ack_err,
  output logic [31:0]          dac_data,
  output logic                 dac_valid,
  input  logic                 dac_ready,
  input  logic [31:0]          adc_data,
  input  logic                 adc_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [2:0] ADDR_I2C    = 3'h0;
  localparam logic [2:0] ADDR_DAC    = 3'h1;
  localparam logic [2:0] ADDR_ADC    = 3'h2;
  localparam logic [2:0] ADDR_STATUS = 3'h3;
  localparam logic [2:0] ADDR_IRQ_EN = 3'h4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DONE  = 3'd2,
    WR_STALL = 3'd3,
    BURST    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        cs_rd_s, cs_wr_s;
  logic [2:0]  addr_s;
  logic        wr_ready_s, waitreq_s;
  logic        wr_accept_s, rd_capture_s, burst_start_s, burst_capture_s, beat_done_s;
  logic [31:0] read_mux_s, status_s, readdata_r;

  logic [31:0] i2c_data_r;
  logic [23:0] i2c_packet_r;
  logic        i2c_start_r;
  logic [2:0]  irq_en_r;
  logic        ack_err_r, irq_r;
  logic        status_wr_s;

  logic [31:0]      dac_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] dac_wr_ptr_r, dac_rd_ptr_r;
  logic [CNT_W-1:0] dac_count_r;
  logic             dac_full_s, dac_empty_s, dac_push_s, dac_pop_s;

  // ADC-side view shared by the FSM, status and IRQ logic in both builds
  logic        adc_empty_s, adc_ovf_s, adc_irq_s;
  logic [31:0] adc_head_s;
  logic        burst_req_s, rd_block_s, beat_valid_s, last_beat_s;

  assign cs_rd_s     = avs.slave_chipselect & avs.slave_read;
  assign cs_wr_s     = avs.slave_chipselect & avs.slave_write;
  assign addr_s      = avs.slave_address;
  assign status_wr_s = wr_accept_s & (addr_s == ADDR_STATUS);

  assign dac_full_s  = (dac_count_r == CNT_FULL);
  assign dac_empty_s = (dac_count_r == CNT_ZERO);
  assign dac_valid   = ~dac_empty_s;
  assign dac_data    = dac_mem_r[dac_rd_ptr_r];
  assign dac_pop_s   = dac_valid & dac_ready;
  assign dac_push_s  = wr_accept_s & (addr_s == ADDR_DAC);

`ifdef WM8731_ADC_PATH_EN
  logic [31:0]      adc_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] adc_wr_ptr_r, adc_rd_ptr_r;
  logic [CNT_W-1:0] adc_count_r;
  logic             adc_full_s, adc_push_s, adc_pop_s, adc_ovf_r;
  logic [7:0]       beats_r;
  logic             beat_valid_r;

  assign adc_full_s   = (adc_count_r == CNT_FULL);
  assign adc_empty_s  = (adc_count_r == CNT_ZERO);
  assign adc_head_s   = adc_mem_r[adc_rd_ptr_r];
  assign adc_push_s   = adc_valid & ~adc_full_s;
  assign adc_pop_s    = (rd_capture_s & (addr_s == ADDR_ADC)) | burst_capture_s;
  assign adc_ovf_s    = adc_ovf_r;
  assign adc_irq_s    = irq_en_r[0] & ~adc_empty_s;
  assign burst_req_s  = avs.slave_beginbursttransfer & (addr_s == ADDR_ADC);
  assign rd_block_s   = (addr_s == ADDR_ADC) & adc_empty_s;
  assign beat_valid_s = beat_valid_r;
  assign last_beat_s  = (beats_r == 8'd1);

  // ADC FIFO: push incoming samples unless full, pop on completed ADC reads/beats
  always_ff @(posedge Clk) begin
    if (Reset) begin
      adc_wr_ptr_r <= {PTR_W{1'b0}};
      adc_rd_ptr_r <= {PTR_W{1'b0}};
      adc_count_r  <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) adc_mem_r[i] <= 32'h0;
    end else begin
      if (adc_push_s) begin
        adc_mem_r[adc_wr_ptr_r] <= adc_data;
        adc_wr_ptr_r            <= adc_wr_ptr_r + PTR_W'(1);
      end
      if (adc_pop_s) adc_rd_ptr_r <= adc_rd_ptr_r + PTR_W'(1);
      case ({adc_push_s, adc_pop_s})
        2'b10:   adc_count_r <= adc_count_r + CNT_W'(1);
        2'b01:   adc_count_r <= adc_count_r - CNT_W'(1);
        default: adc_count_r <= adc_count_r;
      endcase
    end
  end

  // Sticky overflow flag: a sample dropped on a full FIFO wins over a same-cycle clear
  always_ff @(posedge Clk) begin
    if (Reset) adc_ovf_r <= 1'b0;
    else       adc_ovf_r <= (adc_valid & adc_full_s) |
                            (adc_ovf_r & ~(status_wr_s & avs.slave_writedata[5]));
  end

  // Burst bookkeeping: remaining beats and whether the current beat's data is loaded
  always_ff @(posedge Clk) begin
    if (Reset) begin
      beats_r      <= 8'd0;
      beat_valid_r <= 1'b0;
    end else if (burst_start_s) begin
      beats_r      <= (avs.slave_burstcount == 8'd0) ? 8'd1 : avs.slave_burstcount;
      beat_valid_r <= 1'b0;
    end else if (burst_capture_s) begin
      beat_valid_r <= 1'b1;
    end else if (beat_done_s) begin
      beats_r      <= beats_r - 8'd1;
      beat_valid_r <= 1'b0;
    end else begin
      beats_r      <= beats_r;
      beat_valid_r <= beat_valid_r;
    end
  end
`else
  assign adc_empty_s  = 1'b1;
  assign adc_ovf_s    = 1'b0;
  assign adc_irq_s    = 1'b0;
  assign adc_head_s   = 32'h0;
  assign burst_req_s  = 1'b0;
  assign rd_block_s   = 1'b0;
  assign beat_valid_s = 1'b0;
  assign last_beat_s  = 1'b0;

  logic unused_adc_s;
  assign unused_adc_s = ^{adc_data, adc_valid, avs.slave_beginbursttransfer,
                          avs.slave_burstcount, burst_capture_s, beat_done_s};
`endif

  // Write readiness of the addressed target
  always_comb begin
    wr_ready_s = 1'b1;
    case (addr_s)
      ADDR_I2C: wr_ready_s = ~i2c_busy;
      ADDR_DAC: wr_ready_s = ~dac_full_s | dac_pop_s;
      default:  wr_ready_s = 1'b1;
    endcase
  end

  // FSM next state, waitrequest and transfer strobes
  always_comb begin
    state_s         = state_r;
    waitreq_s       = 1'b0;
    wr_accept_s     = 1'b0;
    rd_capture_s    = 1'b0;
    burst_start_s   = 1'b0;
    burst_capture_s = 1'b0;
    beat_done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_rd_s) begin
          waitreq_s = 1'b1;
          if (burst_req_s) begin
            burst_start_s = 1'b1;
            state_s       = BURST;
          end else if (rd_block_s) begin
            state_s = IDLE;
          end else begin
            rd_capture_s = 1'b1;
            state_s      = RD_WAIT;
          end
        end else if (cs_wr_s) begin
          if (wr_ready_s) begin
            wr_accept_s = 1'b1;
          end else begin
            waitreq_s = 1'b1;
            state_s   = WR_STALL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: state_s = RD_DONE;
      RD_DONE: state_s = IDLE;
      WR_STALL: begin
        if (cs_wr_s) begin
          if (wr_ready_s) begin
            wr_accept_s = 1'b1;
            state_s     = IDLE;
          end else begin
            waitreq_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (!beat_valid_s) begin
          waitreq_s = 1'b1;
          if (!adc_empty_s) burst_capture_s = 1'b1;
          else              burst_capture_s = 1'b0;
        end else begin
          beat_done_s = 1'b1;
          if (last_beat_s) state_s = IDLE;
          else             state_s = BURST;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // STATUS word assembled from live flags
  assign status_s = {26'h0, adc_ovf_s, adc_empty_s, dac_empty_s, dac_full_s, ack_err_r, i2c_busy};

  // Register read multiplexer
  always_comb begin
    read_mux_s = 32'h0;
    case (addr_s)
      ADDR_I2C:    read_mux_s = i2c_data_r;
      ADDR_ADC:    read_mux_s = adc_head_s;
      ADDR_STATUS: read_mux_s = status_s;
      ADDR_IRQ_EN: read_mux_s = {29'h0, irq_en_r};
      default:     read_mux_s = 32'h0;
    endcase
  end

  // Read data register, loaded when a single read or burst beat is taken
  always_ff @(posedge Clk) begin
    if (Reset)                readdata_r <= 32'h0;
    else if (rd_capture_s)    readdata_r <= read_mux_s;
    else if (burst_capture_s) readdata_r <= adc_head_s;
    else                      readdata_r <= readdata_r;
  end

  // I2C data register, packet and one-cycle start pulse on an accepted write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      i2c_data_r   <= 32'h0;
      i2c_packet_r <= 24'h0;
      i2c_start_r  <= 1'b0;
    end else if (wr_accept_s && addr_s == ADDR_I2C) begin
      i2c_data_r   <= avs.slave_writedata;
      i2c_packet_r <= avs.slave_writedata[23:0];
      i2c_start_r  <= 1'b1;
    end else begin
      i2c_start_r  <= 1'b0;
    end
  end

  // IRQ enable register and sticky ack error (a same-cycle set beats the clear)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      irq_en_r  <= 3'h0;
      ack_err_r <= 1'b0;
    end else begin
      if (wr_accept_s && addr_s == ADDR_IRQ_EN) irq_en_r <= avs.slave_writedata[2:0];
      ack_err_r <= i2c_ack_err | (ack_err_r & ~(status_wr_s & avs.slave_writedata[1]));
    end
  end

  // Registered interrupt request
  always_ff @(posedge Clk) begin
    if (Reset) irq_r <= 1'b0;
    else       irq_r <= adc_irq_s | (irq_en_r[1] & dac_empty_s) | (irq_en_r[2] & ack_err_r);
  end

  // DAC FIFO: push on accepted DAC_AUDIO writes, pop on dac_valid & dac_ready
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dac_wr_ptr_r <= {PTR_W{1'b0}};
      dac_rd_ptr_r <= {PTR_W{1'b0}};
      dac_count_r  <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) dac_mem_r[i] <= 32'h0;
    end else begin
      if (dac_push_s) begin
        dac_mem_r[dac_wr_ptr_r] <= avs.slave_writedata;
        dac_wr_ptr_r            <= dac_wr_ptr_r + PTR_W'(1);
      end
      if (dac_pop_s) dac_rd_ptr_r <= dac_rd_ptr_r + PTR_W'(1);
      case ({dac_push_s, dac_pop_s})
        2'b10:   dac_count_r <= dac_count_r + CNT_W'(1);
        2'b01:   dac_count_r <= dac_count_r - CNT_W'(1);
        default: dac_count_r <= dac_count_r;
      endcase
    end
  end

  assign avs.slave_readdata    = readdata_r;
  assign avs.slave_waitrequest = waitreq_s & ~Reset;
  assign avs.slave_irq         = irq_r;
  assign i2c_start             = i2c_start_r;
  assign i2c_packet            = i2c_packet_r;

endmodule

// File: tb/tb_wm8731_avalon_slave.sv
// tb_wm8731_avalon_slave: directed self-checking bench for wm8731_avalon_slave
// (FIFO_DEPTH = 4). ADC-path scenarios are built when WM8731_ADC_PATH_EN is defined.

module tb_wm8731_avalon_slave;
  logic        Clk;
  logic        Reset;
  logic        i2c_start, i2c_busy, i2c_ack_err;
  logic [23:0] i2c_packet;
  logic [31:0] dac_data, adc_data;
  logic        dac_valid, dac_ready, adc_valid;

  int compared   = 0;
  int mismatched = 0;
  int start_cnt  = 0;

  wm8731_avalon_slave_if bus ();

  wm8731_avalon_slave #(.FIFO_DEPTH(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .avs        (bus.slave),
    .i2c_start  (i2c_start),
    .i2c_packet (i2c_packet),
    .i2c_busy   (i2c_busy),
    .i2c_ack_err(i2c_ack_err),
    .dac_data   (dac_data),
    .dac_valid  (dac_valid),
    .dac_ready  (dac_ready),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count i2c_start pulses seen at clock edges
  always @(posedge Clk) if (i2c_start) start_cnt <= start_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic avm_write(input logic [2:0] a, input logic [31:0] d, output int waits);
    waits = 0;
    @(negedge Clk);
    bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1;
    bus.slave_address = a; bus.slave_writedata = d;
    forever begin
      #1;
      if (!bus.slave_waitrequest) break;
      if (waits == 50) begin
        compared++; mismatched++;
        $error("FAIL wr_timeout observed=%0d expected=<50", waits);
        break;
      end
      waits++;
      @(negedge Clk);
    end
    @(posedge Clk); #1;
    bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0;
    @(posedge Clk);
  endtask

  task automatic avm_read(input logic [2:0] a, output logic [31:0] d);
    int n;
    n = 0; d = 32'h0;
    @(negedge Clk);
    bus.slave_chipselect = 1'b1; bus.slave_read = 1'b1; bus.slave_address = a;
    forever begin
      #1;
      if (!bus.slave_waitrequest) begin d = bus.slave_readdata; break; end
      if (n == 50) begin
        compared++; mismatched++;
        $error("FAIL rd_timeout observed=%0d expected=<50", n);
        break;
      end
      n++;
      @(negedge Clk);
    end
    @(posedge Clk); #1;
    bus.slave_chipselect = 1'b0; bus.slave_read = 1'b0;
    @(posedge Clk);
  endtask

  task automatic adc_push(input logic [31:0] d);
    @(negedge Clk); adc_data = d; adc_valid = 1'b1;
    @(negedge Clk); adc_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int w, s0, nw, n, cyc, stall;
    logic [31:0] got [4];

    Reset = 1'b1; i2c_busy = 1'b0; i2c_ack_err = 1'b0; dac_ready = 1'b0;
    adc_data = 32'h0; adc_valid = 1'b0;
    bus.slave_read = 1'b0; bus.slave_write = 1'b0; bus.slave_chipselect = 1'b0;
    bus.slave_beginbursttransfer = 1'b0; bus.slave_address = 3'h0;
    bus.slave_writedata = 32'h0; bus.slave_burstcount = 8'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); #1;
    check("rst_waitrequest", {31'h0, bus.slave_waitrequest}, 32'h0);
    check("rst_readdata", bus.slave_readdata, 32'h0);
    check("rst_irq", {31'h0, bus.slave_irq}, 32'h0);
    check("rst_i2c_start", {31'h0, i2c_start}, 32'h0);
    check("rst_i2c_packet", {8'h0, i2c_packet}, 32'h0);
    check("rst_dac_valid", {31'h0, dac_valid}, 32'h0);
    check("rst_dac_data", dac_data, 32'h0);
    Reset = 1'b0;

    avm_read(3'h3, rd); check("status_after_reset", rd, 32'h18);

    // I2C write with i2c_busy low: zero-wait, one start pulse
    s0 = start_cnt;
    avm_write(3'h0, 32'h00341E97, w);
    #1;
    check("i2c_wr_waits", w, 32'd0);
    check("i2c_start_pulses", start_cnt - s0, 32'd1);
    check("i2c_packet", {8'h0, i2c_packet}, 32'h00341E97);
    check("i2c_start_low_after", {31'h0, i2c_start}, 32'h0);
    avm_read(3'h0, rd); check("i2c_readback", rd, 32'h00341E97);

    // I2C write while busy for 5 cycles
    s0 = start_cnt; nw = 0;
    @(negedge Clk);
    i2c_busy = 1'b1; bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1;
    bus.slave_address = 3'h0; bus.slave_writedata = 32'h00123456;
    for (int i = 0; i < 5; i++) begin
      #1; if (bus.slave_waitrequest) nw++;
      @(negedge Clk);
    end
    i2c_busy = 1'b0; #1;
    check("busy_wait_cycles", nw, 32'd5);
    check("busy_release_waitreq", {31'h0, bus.slave_waitrequest}, 32'h0);
    check("busy_no_early_start", start_cnt - s0, 32'd0);
    @(posedge Clk); #1;
    bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0;
    @(posedge Clk); #1;
    check("busy_start_pulses", start_cnt - s0, 32'd1);
    check("busy_packet", {8'h0, i2c_packet}, 32'h00123456);

    // Sticky ack error, write-1-to-clear, set wins over clear
    @(negedge Clk); i2c_ack_err = 1'b1;
    @(negedge Clk); i2c_ack_err = 1'b0;
    avm_read(3'h3, rd); check("status_ack_err", rd, 32'h1A);
    @(negedge Clk);
    bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1;
    bus.slave_address = 3'h3; bus.slave_writedata = 32'h2; i2c_ack_err = 1'b1;
    @(posedge Clk); #1;
    bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0; i2c_ack_err = 1'b0;
    @(posedge Clk);
    avm_read(3'h3, rd); check("ack_set_beats_clear", rd, 32'h1A);
    avm_write(3'h3, 32'h2, w);
    avm_read(3'h3, rd); check("ack_cleared", rd, 32'h18);

    // IRQ enable register and interrupt sources
    avm_write(3'h4, 32'hFFFFFFFF, w);
    avm_read(3'h4, rd); check("irq_en_readback", rd, 32'h7);
    #1; check("irq_dac_empty", {31'h0, bus.slave_irq}, 32'h1);
    avm_write(3'h4, 32'h4, w); #1;
    check("irq_masked", {31'h0, bus.slave_irq}, 32'h0);
    @(negedge Clk); i2c_ack_err = 1'b1;
    @(negedge Clk); i2c_ack_err = 1'b0;
    @(negedge Clk); #1;
    check("irq_ack_err", {31'h0, bus.slave_irq}, 32'h1);
    avm_write(3'h3, 32'h2, w);
    avm_write(3'h4, 32'h0, w); #1;
    check("irq_off", {31'h0, bus.slave_irq}, 32'h0);

    // Unmapped and write-only addresses
    avm_write(3'h5, 32'hDEADBEEF, w);
    avm_read(3'h5, rd); check("unmapped_5", rd, 32'h0);
    avm_read(3'h7, rd); check("unmapped_7", rd, 32'h0);
    avm_read(3'h1, rd); check("dac_write_only", rd, 32'h0);

`ifndef WM8731_ADC_PATH_EN
    // ADC path absent: samples ignored, ADC_AUDIO reads zero
    avm_write(3'h4, 32'h1, w);
    adc_push(32'hCAFE0001);
    avm_read(3'h2, rd); check("adc_disabled_read", rd, 32'h0);
    avm_read(3'h3, rd); check("adc_disabled_status", rd, 32'h18);
    #1; check("adc_disabled_irq", {31'h0, bus.slave_irq}, 32'h0);
    avm_write(3'h4, 32'h0, w);
`endif

    // DAC FIFO fill, stall on full, simultaneous push/pop, drain order
    for (int i = 1; i <= 4; i++) begin
      avm_write(3'h1, i, w); check("dac_wr_no_wait", w, 32'd0);
    end
    avm_read(3'h3, rd); check("status_dac_full", rd, 32'h14);
    @(negedge Clk);
    bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1;
    bus.slave_address = 3'h1; bus.slave_writedata = 32'd5;
    #1; check("dac_stall_1", {31'h0, bus.slave_waitrequest}, 32'h1);
    @(negedge Clk); #1;
    check("dac_stall_2", {31'h0, bus.slave_waitrequest}, 32'h1);
    check("dac_head_1", dac_data, 32'd1);
    dac_ready = 1'b1; #1;
    check("dac_stall_release", {31'h0, bus.slave_waitrequest}, 32'h0);
    @(posedge Clk); #1;
    bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0;
    check("dac_seq_2", dac_data, 32'd2);
    for (int k = 3; k <= 5; k++) begin
      @(posedge Clk); #1; check("dac_seq", dac_data, k);
    end
    @(posedge Clk); #1;
    check("dac_drained", {31'h0, dac_valid}, 32'h0);
    dac_ready = 1'b0;

`ifdef WM8731_ADC_PATH_EN
    // Burst of 4 with 3 samples queued; 4th beat waits for the 4th sample
    adc_push(32'hA);
    adc_push(32'hB);
    adc_push(32'hC);
    n = 0; cyc = 0; stall = 0;
    @(negedge Clk);
    bus.slave_chipselect = 1'b1; bus.slave_read = 1'b1; bus.slave_beginbursttransfer = 1'b1;
    bus.slave_address = 3'h2; bus.slave_burstcount = 8'd4;
    while (n < 4 && cyc < 60) begin
      #1;
      if (!bus.slave_waitrequest) begin got[n] = bus.slave_readdata; n++; end
      else if (n == 3) stall++;
      @(negedge Clk); cyc++;
      bus.slave_beginbursttransfer = 1'b0;
      adc_data = 32'hD; adc_valid = (n == 3 && stall == 3);
    end
    adc_valid = 1'b0;
    bus.slave_chipselect = 1'b0; bus.slave_read = 1'b0;
    @(posedge Clk);
    check("burst_beats", n, 32'd4);
    check("burst_beat_a", got[0], 32'hA);
    check("burst_beat_b", got[1], 32'hB);
    check("burst_beat_c", got[2], 32'hC);
    check("burst_beat_d", got[3], 32'hD);
    check("burst_stalled", {31'h0, stall >= 3}, 32'h1);
    avm_read(3'h3, rd); check("status_after_burst", rd, 32'h18);

    // Overflow on a full ADC FIFO and the ADC-not-empty interrupt
    avm_write(3'h4, 32'h1, w);
    @(negedge Clk); adc_data = 32'h100; adc_valid = 1'b1; #1;
    check("adc_irq_pre", {31'h0, bus.slave_irq}, 32'h0);
    @(negedge Clk); adc_data = 32'h101; #1;
    check("adc_irq_lag", {31'h0, bus.slave_irq}, 32'h0);
    @(negedge Clk); adc_data = 32'h102; #1;
    check("adc_irq_set", {31'h0, bus.slave_irq}, 32'h1);
    @(negedge Clk); adc_data = 32'h103;
    @(negedge Clk); adc_data = 32'h104;
    @(negedge Clk); adc_valid = 1'b0;
    avm_read(3'h3, rd); check("status_overflow", rd, 32'h28);
    avm_write(3'h3, 32'h20, w);
    avm_read(3'h3, rd); check("overflow_cleared", rd, 32'h08);
    for (int k = 0; k < 4; k++) begin
      avm_read(3'h2, rd); check("adc_single_read", rd, 32'h100 + k);
    end
    avm_read(3'h3, rd); check("adc_drained_status", rd, 32'h18);
    avm_write(3'h4, 32'h0, w);
`endif

    // Reset in the middle of a DAC-write stall
    for (int i = 1; i <= 4; i++) avm_write(3'h1, 32'h40 + i, w);
    @(negedge Clk);
    bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1;
    bus.slave_address = 3'h1; bus.slave_writedata = 32'h45;
    #1; check("rst_stall_pre", {31'h0, bus.slave_waitrequest}, 32'h1);
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    check("rst_stall_waitreq", {31'h0, bus.slave_waitrequest}, 32'h0);
    check("rst_stall_dac_valid", {31'h0, dac_valid}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0; bus.slave_chipselect = 1'b0; bus.slave_write = 1'b0;
    #1; check("rst_stall_idle_waitreq", {31'h0, bus.slave_waitrequest}, 32'h0);
    avm_read(3'h3, rd); check("rst_stall_status", rd, 32'h18);
    avm_read(3'h0, rd); check("rst_stall_i2c_cleared", rd, 32'h0);
    check("rst_stall_packet", {8'h0, i2c_packet}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
